// File: rtl/uart_pkg.sv
// uart_pkg: shared register offsets, status bit positions and FSM state
// encodings for the memory-mapped UART.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with two-flop synchroniser and mid-bit sampling.
// Ports: clk, reset_n, rx_in (async pin); byte_valid/frame_err are 1-cycle
// pulses, rx_byte holds the last assembled byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                // prev_q high guarantees the line was idle before the edge,
                // so a low line after a bad stop bit cannot restart a frame.
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LAST;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = BIT_LAST;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    cnt_d   = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
    assign rx_byte    = shreg_q;

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: polled 8N1 UART on the rv32 data bus (DATA and STATUS regs).
// Ports: clk/reset_n, bus sel/read/mask/address/value in, registered
// read_value_out (0 when unselected), uart_rx pin in, uart_tx pin out.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0] reg_sel;
    logic       wr_data, wr_status, rd_data;
    logic       unused_bus;

    assign reg_sel   = address_in[3:2];
    assign wr_data   = sel_in && write_mask_in[0] && (reg_sel == REG_DATA);
    assign wr_status = sel_in && write_mask_in[0] && (reg_sel == REG_STATUS);
    assign rd_data   = sel_in && read_in && (reg_sel == REG_DATA);
    assign unused_bus = ^{address_in[31:4], address_in[1:0],
                          write_value_in[31:8], write_mask_in[3:1]};

    logic       rx_byte_valid, rx_frame_err;
    logic [7:0] rx_byte;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_in      (uart_rx),
        .byte_valid (rx_byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (rx_frame_err)
    );

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shreg_q, tx_shreg_d;
    logic             tx_q, tx_d;
    logic             tx_tick, tx_busy;

    assign tx_tick = (tx_cnt_q == '0);
    assign tx_busy = (tx_state_q != TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (wr_data) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = BIT_LAST;
                    tx_shreg_d = write_value_in[7:0];
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_LAST;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_cnt_d   = BIT_LAST;
                    tx_shreg_d = {1'b1, tx_shreg_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level follows the next state so uart_tx is a clean flop.
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status_word;
    logic        accept;

    always_comb begin
        // A DATA read on the same edge frees the holding register.
        accept     = rx_byte_valid && (!rx_valid_q || rd_data);
        rx_valid_d = rx_valid_q;
        if (rd_data) rx_valid_d = 1'b0;
        if (accept)  rx_valid_d = 1'b1;
        rx_data_d = accept ? rx_byte : rx_data_q;

        overrun_d = overrun_q;
        if (wr_status && write_value_in[ST_OVERRUN]) overrun_d = 1'b0;
        if (rx_byte_valid && !accept) overrun_d = 1'b1;

        frame_err_d = frame_err_q;
        if (wr_status && write_value_in[ST_FRAME_ERR]) frame_err_d = 1'b0;
        if (rx_frame_err) frame_err_d = 1'b1;

        status_word               = '0;
        status_word[ST_TX_BUSY]   = tx_busy;
        status_word[ST_RX_VALID]  = rx_valid_q;
        status_word[ST_OVERRUN]   = overrun_q;
        status_word[ST_FRAME_ERR] = frame_err_q;

        rdata_d = '0;
        if (sel_in) begin
            case (reg_sel)
                REG_DATA:   rdata_d = {24'd0, rx_data_q};
                REG_STATUS: rdata_d = status_word;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_shreg_q  <= 8'd0;
            tx_q        <= 1'b1;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= 8'd0;
            rdata_q     <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shreg_q  <= tx_shreg_d;
            tx_q        <= tx_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rdata_q     <= rdata_d;
        end
    end

    assign uart_tx        = tx_q;
    assign read_value_out = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench for uart_mmio at 4 clocks per bit.
// Drives bus and rx pin on negedges, samples on negedges.
module tb_uart_mmio;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [3:0]  write_mask_in = 4'd0;
    logic [31:0] address_in = 32'd0;
    logic [31:0] write_value_in = 32'd0;
    logic [31:0] read_value_out;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_mmio #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .write_mask_in  (write_mask_in),
        .address_in     (address_in),
        .write_value_in (write_value_in),
        .read_value_out (read_value_out),
        .uart_rx        (uart_rx),
        .uart_tx        (uart_tx)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [1:0] idx);
        return {28'd0, idx, 2'b00};
    endfunction

    // Expected line level i cycles after the edge that accepted the write.
    function automatic logic tx_bit(input logic [7:0] b, input int i);
        int slot;
        if (i < 1 || i > 10 * CPB) return 1'b1;
        slot = (i - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] val,
                             input logic [3:0] mask);
        sel_in = 1'b1;
        address_in = reg_addr(idx);
        write_value_in = val;
        write_mask_in = mask;
        @(negedge clk);
        sel_in = 1'b0;
        write_mask_in = 4'd0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] idx,
                              input logic [31:0] exp);
        sel_in = 1'b1;
        read_in = 1'b1;
        address_in = reg_addr(idx);
        @(negedge clk);
        sel_in = 1'b0;
        read_in = 1'b0;
        check(tag, read_value_out, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        cyc(CPB);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            cyc(CPB);
        end
        uart_rx = stop;
        cyc(CPB);
        uart_rx = 1'b1;
    endtask

    initial begin
        cyc(3);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_rdata", read_value_out, 32'd0);
        reset_n = 1'b1;
        cyc(1);
        read_check("rst_status", REG_STATUS, 32'h0);
        read_check("rst_data", REG_DATA, 32'h0);

        // TX 0xA5 while STATUS stays selected to watch tx_busy
        sel_in = 1'b1;
        address_in = reg_addr(REG_DATA);
        write_value_in = 32'hA5;
        write_mask_in = 4'b0001;
        @(negedge clk);
        write_mask_in = 4'd0;
        address_in = reg_addr(REG_STATUS);
        for (int i = 1; i <= 44; i++) begin
            check($sformatf("tx_a5_line[%0d]", i), {31'd0, uart_tx},
                  {31'd0, tx_bit(8'hA5, i)});
            if (i >= 2)
                check($sformatf("tx_a5_busy[%0d]", i), read_value_out,
                      (i <= 41) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        sel_in = 1'b0;

        // TX drop: second write while busy must not disturb the frame
        bus_write(REG_DATA, 32'h55, 4'b0001);
        for (int i = 1; i <= 90; i++) begin
            if (i == 2) begin
                sel_in = 1'b1;
                address_in = reg_addr(REG_DATA);
                write_value_in = 32'h0F;
                write_mask_in = 4'b0001;
            end else begin
                sel_in = 1'b0;
                write_mask_in = 4'd0;
            end
            check($sformatf("tx_drop_line[%0d]", i), {31'd0, uart_tx},
                  {31'd0, tx_bit(8'h55, i)});
            @(negedge clk);
        end
        sel_in = 1'b0;
        write_mask_in = 4'd0;
        read_check("tx_drop_idle", REG_STATUS, 32'h0);

        // RX single byte
        send_frame(8'h3C, 1'b1);
        cyc(6);
        read_check("rx_status", REG_STATUS, 32'h2);
        read_check("rx_data", REG_DATA, 32'h3C);
        read_check("rx_status_clr", REG_STATUS, 32'h0);

        // RX overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cyc(6);
        read_check("ovr_status", REG_STATUS, 32'h6);
        bus_write(REG_STATUS, 32'h4, 4'b0001);
        read_check("ovr_w1c", REG_STATUS, 32'h2);
        read_check("ovr_data", REG_DATA, 32'h11);
        read_check("ovr_empty", REG_STATUS, 32'h0);

        // RX frame error keeps the held byte
        send_frame(8'h44, 1'b1);
        send_frame(8'h99, 1'b0);
        cyc(6);
        read_check("ferr_status", REG_STATUS, 32'hA);
        read_check("ferr_data", REG_DATA, 32'h44);
        bus_write(REG_STATUS, 32'h8, 4'b0001);
        read_check("ferr_w1c", REG_STATUS, 32'h0);

        // RX glitch
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        cyc(10);
        read_check("glitch_status", REG_STATUS, 32'h0);
        check("glitch_fsm", {30'd0, dut.u_rx.state_q}, {30'd0, RX_IDLE});
        send_frame(8'h5A, 1'b1);
        cyc(6);

        // Bus isolation with a byte pending
        sel_in = 1'b0;
        read_in = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address_in = reg_addr(a[1:0]);
            @(negedge clk);
            check($sformatf("nosel_addr%0d", a), read_value_out, 32'h0);
        end
        read_in = 1'b0;
        read_check("rsvd2", 2'd2, 32'h0);
        read_check("rsvd3", 2'd3, 32'h0);
        read_check("glitch_after_status", REG_STATUS, 32'h2);
        read_check("glitch_after_data", REG_DATA, 32'h5A);

        // Reset mid TX with every flag raised
        send_frame(8'h77, 1'b1);
        send_frame(8'h88, 1'b1);
        cyc(6);
        bus_write(REG_DATA, 32'h00, 4'b0001);
        cyc(4);
        read_check("pre_rst_status", REG_STATUS, 32'h7);
        cyc(4);
        check("pre_rst_line", {31'd0, uart_tx}, 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_line", {31'd0, uart_tx}, 32'd1);
        check("mid_rst_rdata", read_value_out, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        read_check("post_rst_status", REG_STATUS, 32'h0);
        read_check("post_rst_data", REG_DATA, 32'h0);
        check("post_rst_line", {31'd0, uart_tx}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
